// File: rtl/temp_alarm_ctrl_if.sv
// Temperature-alarm bus: sample input from the temperature monitor and the
// averaged/alarm results going back out.
//
// Handshake: the monitor presents `temperature` with `ready`; a sample is
// taken once per low-to-high transition of `ready` (holding `ready` high
// does not retake it). `avg_valid` is a one-cycle pulse marking the cycle
// in which `avg_temp` carries a freshly updated average; there is no
// back-pressure on the result side.
interface temp_alarm_ctrl_if;
    logic [7:0] temperature;
    logic       ready;
    logic       alarm_ack;
    logic [7:0] avg_temp;
    logic       avg_valid;
    logic       alarm;
    logic [7:0] peak_temp;

    // Temperature monitor / environment side
    modport master (
        output temperature, ready, alarm_ack,
        input  avg_temp, avg_valid, alarm, peak_temp
    );

    // Alarm controller side
    modport slave (
        input  temperature, ready, alarm_ack,
        output avg_temp, avg_valid, alarm, peak_temp
    );
endinterface

// File: rtl/temp_alarm_ctrl.sv
// Temperature alarm controller: 4-sample moving average, peak capture and a
// debounced hysteresis alarm FSM (NORMAL/RISING/ALARM/FALLING).
// Optional feature: define TEMP_ALARM_LATCH_EN to make the alarm latch until
// acknowledged with alarm_ack while the FSM is back in NORMAL.
module temp_alarm_ctrl #(
    parameter logic [7:0] T_HIGH   = 8'd60,
    parameter logic [7:0] T_LOW    = 8'd55,
    parameter int         DEBOUNCE = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    temp_alarm_ctrl_if.slave    bus,
    output logic [1:0]          dbg_state,
    output logic [3:0]          dbg_cnt
);

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        RISING  = 2'd1,
        ALARM   = 2'd2,
        FALLING = 2'd3
    } state_t;

    localparam logic [3:0] DEB = 4'(DEBOUNCE);

    // Datapath state
    logic       ready_q, ready_d;
    logic [7:0] win_q [4];
    logic [7:0] win_d [4];
    logic [9:0] sum_q, sum_d;
    logic       preload_q, preload_d;
    logic       cap_q, cap_d;
    logic [7:0] avg_temp_q, avg_temp_d;
    logic       avg_valid_q, avg_valid_d;
    logic [7:0] peak_q, peak_d;

    // FSM state
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       alarm_q, alarm_d;

    logic       capture;

    // Capture detection, window shift, running sum, peak and average stage
    always_comb begin
        capture     = bus.ready & ~ready_q;
        ready_d     = bus.ready;
        win_d       = win_q;
        sum_d       = sum_q;
        preload_d   = preload_q;
        peak_d      = peak_q;
        cap_d       = capture;
        avg_valid_d = cap_q;
        avg_temp_d  = cap_q ? sum_q[9:2] : avg_temp_q;

        if (capture) begin
            if (!preload_q) begin
                // First sample after reset fills the whole window.
                for (int i = 0; i < 4; i++) win_d[i] = bus.temperature;
                sum_d     = {bus.temperature, 2'b00};
                preload_d = 1'b1;
            end else begin
                win_d[0] = bus.temperature;
                for (int i = 1; i < 4; i++) win_d[i] = win_q[i-1];
                sum_d = sum_q - {2'b00, win_q[3]} + {2'b00, bus.temperature};
            end
            peak_d = (bus.temperature > peak_q) ? bus.temperature : peak_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q     <= 1'b0;
            for (int i = 0; i < 4; i++) win_q[i] <= 8'd0;
            sum_q       <= 10'd0;
            preload_q   <= 1'b0;
            cap_q       <= 1'b0;
            avg_temp_q  <= 8'd0;
            avg_valid_q <= 1'b0;
            peak_q      <= 8'd0;
        end else begin
            ready_q     <= ready_d;
            win_q       <= win_d;
            sum_q       <= sum_d;
            preload_q   <= preload_d;
            cap_q       <= cap_d;
            avg_temp_q  <= avg_temp_d;
            avg_valid_q <= avg_valid_d;
            peak_q      <= peak_d;
        end
    end

    // Hysteresis/debounce next-state; only advances on a fresh average
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (avg_valid_q) begin
            case (state_q)
                NORMAL: begin
                    if (avg_temp_q >= T_HIGH) begin
                        if (DEB == 4'd1) begin
                            state_d = ALARM;
                            cnt_d   = 4'd0;
                        end else begin
                            state_d = RISING;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                RISING: begin
                    if (avg_temp_q >= T_HIGH) begin
                        if (cnt_q + 4'd1 == DEB) begin
                            state_d = ALARM;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = NORMAL;
                        cnt_d   = 4'd0;
                    end
                end
                ALARM: begin
                    if (avg_temp_q <= T_LOW) begin
                        if (DEB == 4'd1) begin
                            state_d = NORMAL;
                            cnt_d   = 4'd0;
                        end else begin
                            state_d = FALLING;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                FALLING: begin
                    if (avg_temp_q <= T_LOW) begin
                        if (cnt_q + 4'd1 == DEB) begin
                            state_d = NORMAL;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = ALARM;
                        cnt_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = NORMAL;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

`ifdef TEMP_ALARM_LATCH_EN
    // Latched alarm: set on entering ALARM, cleared only by an ack in NORMAL
    always_comb begin
        alarm_d = alarm_q;
        if (state_d == ALARM && state_q != ALARM)
            alarm_d = 1'b1;
        else if (bus.alarm_ack && state_q == NORMAL)
            alarm_d = 1'b0;
    end
`else
    // Follow-mode alarm: asserted while over temperature or still debouncing down
    logic unused_alarm_ack;
    assign unused_alarm_ack = bus.alarm_ack;

    always_comb begin
        alarm_d = (state_d == ALARM) || (state_d == FALLING);
    end
`endif

    // FSM registers with registered alarm output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NORMAL;
            cnt_q   <= 4'd0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
        end
    end

    assign bus.avg_temp  = avg_temp_q;
    assign bus.avg_valid = avg_valid_q;
    assign bus.alarm     = alarm_q;
    assign bus.peak_temp = peak_q;
    assign dbg_state     = state_q;
    assign dbg_cnt       = cnt_q;

endmodule

// File: tb/tb_temp_alarm_ctrl.sv
// Testbench for temp_alarm_ctrl: directed captures, a reference window model
// feeding an expected queue, and a monitor that checks every avg_valid pulse.
module tb_temp_alarm_ctrl;

    localparam logic [1:0] S_NORMAL  = 2'd0;
    localparam logic [1:0] S_RISING  = 2'd1;
    localparam logic [1:0] S_ALARM   = 2'd2;
    localparam logic [1:0] S_FALLING = 2'd3;

`ifdef TEMP_ALARM_LATCH_EN
    localparam logic LATCHED = 1'b1;
`else
    localparam logic LATCHED = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    logic [3:0] dbg_cnt;

    temp_alarm_ctrl_if bus ();

    temp_alarm_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state),
        .dbg_cnt   (dbg_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q [$];   // {avg, peak}
    int tests = 0;
    int fails = 0;
    int pulses = 0;

    logic [7:0] m_win [4];
    bit         m_pre;
    logic [7:0] m_peak;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_win[i] = 8'd0;
        m_pre  = 1'b0;
        m_peak = 8'd0;
    endtask

    task automatic model_push(input logic [7:0] t);
        logic [9:0] s;
        if (!m_pre) begin
            for (int i = 0; i < 4; i++) m_win[i] = t;
            m_pre = 1'b1;
        end else begin
            for (int i = 3; i > 0; i--) m_win[i] = m_win[i-1];
            m_win[0] = t;
        end
        if (t > m_peak) m_peak = t;
        s = 10'(m_win[0]) + 10'(m_win[1]) + 10'(m_win[2]) + 10'(m_win[3]);
        exp_q.push_back({s[9:2], m_peak});
    endtask

    // Monitor: every avg_valid pulse must match the oldest expectation
    always @(posedge clk) begin
        #1;
        if (rst_n && bus.avg_valid) begin
            logic [15:0] e;
            pulses++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_avg_valid: got avg %0d expected no pulse at %0t",
                         bus.avg_temp, $time);
            end else begin
                e = exp_q.pop_front();
                check("avg_temp", {8'd0, bus.avg_temp}, {8'd0, e[15:8]});
                check("peak_temp", {8'd0, bus.peak_temp}, {8'd0, e[7:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic capture(input logic [7:0] t);
        @(negedge clk);
        bus.temperature = t;
        bus.ready       = 1'b1;
        model_push(t);
        @(negedge clk);
        bus.ready = 1'b0;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        exp_q.delete();
        model_clear();
        #1;
        check("rst_avg_temp", {8'd0, bus.avg_temp}, 16'd0);
        check("rst_avg_valid", {15'd0, bus.avg_valid}, 16'd0);
        check("rst_alarm", {15'd0, bus.alarm}, 16'd0);
        check("rst_peak", {8'd0, bus.peak_temp}, 16'd0);
        check("rst_state", {14'd0, dbg_state}, {14'd0, S_NORMAL});
        check("rst_cnt", {12'd0, dbg_cnt}, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        check("drain_queue_empty", 16'(exp_q.size()), 16'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p0;
        rst_n           = 1'b0;
        bus.temperature = 8'd0;
        bus.ready       = 1'b0;
        bus.alarm_ack   = 1'b0;
        model_clear();
        @(negedge clk);
        reset_dut();

        // Single capture: preload, one-cycle avg_valid, no alarm
        capture(8'd40);
        edge_wait();
        check("valid_at_k1", {15'd0, bus.avg_valid}, 16'd1);
        edge_wait();
        check("valid_gone_k2", {15'd0, bus.avg_valid}, 16'd0);
        check("alarm_after_40", {15'd0, bus.alarm}, 16'd0);
        drain();

        // Three hot captures at max rate: alarm exactly at k+2 of the third
        reset_dut();
        capture(8'd70);
        capture(8'd70);
        capture(8'd70);
        check("alarm_at_k", {15'd0, bus.alarm}, 16'd0);
        edge_wait();
        check("alarm_at_k1", {15'd0, bus.alarm}, 16'd0);
        edge_wait();
        check("alarm_at_k2", {15'd0, bus.alarm}, 16'd1);
        check("state_alarm", {14'd0, dbg_state}, {14'd0, S_ALARM});
        drain();

        // ready held high for 20 cycles: one capture only
        p0 = pulses;
        @(negedge clk);
        bus.temperature = 8'd70;
        bus.ready       = 1'b1;
        model_push(8'd70);
        repeat (20) @(negedge clk);
        bus.ready = 1'b0;
        repeat (4) @(negedge clk);
        check("held_ready_pulses", 16'(pulses - p0), 16'd1);
        drain();

        // Acknowledge while in ALARM is ignored
        @(negedge clk);
        bus.alarm_ack = 1'b1;
        repeat (3) @(negedge clk);
        bus.alarm_ack = 1'b0;
        check("ack_in_alarm_ignored", {15'd0, bus.alarm}, 16'd1);

        // Cool down: averages 65,60,55,50,50
        for (int i = 0; i < 5; i++) capture(8'd50);
        edge_wait();
        check("alarm_5th_k1", {15'd0, bus.alarm}, 16'd1);
        check("state_falling", {14'd0, dbg_state}, {14'd0, S_FALLING});
        edge_wait();
        check("alarm_5th_k2", {15'd0, bus.alarm}, {15'd0, LATCHED});
        check("state_normal", {14'd0, dbg_state}, {14'd0, S_NORMAL});
        drain();

        // Acknowledge in NORMAL clears a latched alarm at the next edge
        @(negedge clk);
        bus.alarm_ack = 1'b1;
        edge_wait();
        check("alarm_after_ack", {15'd0, bus.alarm}, 16'd0);
        @(negedge clk);
        bus.alarm_ack = 1'b0;

        // Hysteresis/debounce abort: 60,60,56 -> 60,60,59
        reset_dut();
        capture(8'd60);
        capture(8'd60);
        edge_wait();
        edge_wait();
        check("rising_cnt2", {12'd0, dbg_cnt}, 16'd2);
        check("state_rising", {14'd0, dbg_state}, {14'd0, S_RISING});
        capture(8'd56);
        edge_wait();
        edge_wait();
        check("abort_cnt0", {12'd0, dbg_cnt}, 16'd0);
        check("abort_state", {14'd0, dbg_state}, {14'd0, S_NORMAL});
        check("abort_alarm", {15'd0, bus.alarm}, 16'd0);
        drain();

        // Reset while in RISING, then fresh preload of 30
        reset_dut();
        capture(8'd70);
        capture(8'd70);
        edge_wait();
        edge_wait();
        check("pre_reset_rising", {14'd0, dbg_state}, {14'd0, S_RISING});
        drain();
        reset_dut();
        capture(8'd30);
        drain();

        // Reset between capture and avg_valid drops the in-flight sample
        capture(8'd90);
        reset_dut();
        capture(8'd20);
        drain();
        check("peak_after_midreset", {8'd0, bus.peak_temp}, 16'd20);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/temp_alarm_ctrl.md
TEMP_ALARM_CTRL -- requirements
Module: temp_alarm_ctrl

Interface
REQ-001 Parameter T_HIGH, default 8'd60: alarm-set threshold in °C, compared as avg >= T_HIGH.
REQ-002 Parameter T_LOW, default 8'd55: alarm-clear threshold in °C, compared as avg <= T_LOW; T_LOW < T_HIGH SHALL hold.
REQ-003 Parameter DEBOUNCE, default 3: consecutive qualifying averages needed to change alarm state; legal range 1..15.
REQ-004 clk  input  1  single system clock; all state SHALL be updated on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 temperature  input  8  unsigned °C sample from the temperature monitor.
REQ-007 ready  input  1  sample-available level from the temperature monitor.
REQ-008 alarm_ack  input  1  alarm acknowledge; used only when TEMP_ALARM_LATCH_EN is defined.
REQ-009 avg_temp  output  8  4-sample moving average.
REQ-010 avg_valid  output  1  one-cycle pulse when avg_temp is updated.
REQ-011 alarm  output  1  over-temperature alarm.
REQ-012 peak_temp  output  8  maximum raw sample captured since reset.

Function
REQ-013 Capture SHALL occur only on a ready 0->1 transition, detected against a registered copy of ready; ready held high SHALL cause exactly one capture.
REQ-014 At capture edge k, temperature SHALL shift into a 4-entry window and the 10-bit window sum SHALL be updated.
REQ-015 The first capture after reset SHALL preload all four window entries with the sample; no warm-up period.
REQ-016 At edge k+1, avg_temp SHALL equal sum[9:2] (truncated) and avg_valid SHALL be high for exactly that one cycle.
REQ-017 At edge k, peak_temp SHALL become max(peak_temp, temperature).
REQ-018 The FSM SHALL evaluate only in cycles where avg_valid is high; alarm therefore changes at edge k+2.
REQ-019 FSM states: NORMAL, RISING, ALARM, FALLING; a 4-bit counter cnt tracks qualifying averages.
REQ-020 NORMAL: avg >= T_HIGH -> cnt=1, next state RISING (ALARM if DEBOUNCE==1); otherwise stay.
REQ-021 RISING: avg >= T_HIGH -> cnt+1, enter ALARM when cnt reaches DEBOUNCE; avg < T_HIGH -> NORMAL, cnt=0.
REQ-022 ALARM: avg <= T_LOW -> cnt=1, next state FALLING (NORMAL if DEBOUNCE==1); otherwise stay.
REQ-023 FALLING: avg <= T_LOW -> cnt+1, enter NORMAL when cnt reaches DEBOUNCE; avg > T_LOW -> ALARM, cnt=0.
REQ-024 Averages strictly between T_LOW and T_HIGH SHALL hold the current alarm state (hysteresis).
REQ-025 Captures two cycles apart SHALL each be processed; no sample is dropped at maximum ready toggle rate.

Reset
REQ-026 While rst_n is low: avg_temp=0, avg_valid=0, alarm=0, peak_temp=0, state=NORMAL, cnt=0, window and sum cleared, preload flag cleared, registered ready=0.
REQ-027 Reset asserted mid-operation (any state, any pipeline stage) SHALL discard all in-flight data; the next capture SHALL preload the window.

Configuration
REQ-028 Macro TEMP_ALARM_LATCH_EN defined: alarm SHALL set on entry to ALARM and SHALL clear only on a clock edge with alarm_ack=1 while state=NORMAL; alarm_ack in any other state SHALL be ignored.
REQ-029 Macro TEMP_ALARM_LATCH_EN undefined: alarm SHALL be 1 exactly when state is ALARM or FALLING; alarm_ack SHALL be ignored.

Verification (defaults T_HIGH=60, T_LOW=55, DEBOUNCE=3)
REQ-030 Reset, then one capture of 40 -> avg_temp=40 with a one-cycle avg_valid at k+1, peak_temp=40, alarm=0.
REQ-031 After reset, captures of 70 x3 -> alarm=1 two cycles after the third capture and not before; ready held high for 20 cycles -> only one capture.
REQ-032 Window at 70 in ALARM, captures of 50 x5 -> averages 65,60,55,50,50; alarm clears at k+2 of the fifth capture (non-latched build).
REQ-033 After reset, captures 60,60,56 -> averages 60,60,59; cnt returns to 0 and alarm stays 0; peak_temp=60.
REQ-034 rst_n pulsed low while in RISING -> all outputs 0 immediately; next capture of 30 -> avg_temp=30.
REQ-035 TEMP_ALARM_LATCH_EN build, REQ-032 stimulus -> alarm stays 1; alarm_ack during ALARM ignored; alarm_ack in NORMAL -> alarm=0 at the next edge.
